// File: rtl/store_buffer_unit.sv
// Store buffer: queues byte-enabled stores and issues them to a bus-wide memory port.
// An unaligned store is split into up to two aligned beats (low, then high). Beats with
// no enabled bytes are skipped.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   write_req/_ready    - store request handshake (accept when both high)
//   write_addr/_data/_byte_enable - store byte address, data (byte 0 in low bits), enables
//   mem_ready           - memory accepts the current beat
//   mem_write_req       - beat valid
//   mem_addr/_write_data/_byte_enable - aligned beat address, data, enables
//   pending_count       - queued entries plus one while a request is in flight
//   idle                - no outstanding work
module store_buffer_unit #(
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         write_ready,
  input  logic                         write_req,
  input  logic [31:0]                  write_addr,
  input  logic [8*BUS_BYTES-1:0]       write_data,
  input  logic [BUS_BYTES-1:0]         write_byte_enable,
  input  logic                         mem_ready,
  output logic [31:0]                  mem_addr,
  output logic [8*BUS_BYTES-1:0]       mem_write_data,
  output logic [BUS_BYTES-1:0]         mem_byte_enable,
  output logic                         mem_write_req,
  output logic [$clog2(DEPTH+2)-1:0]   pending_count,
  output logic                         idle
);

  localparam int unsigned DataW = 8 * BUS_BYTES;
  localparam int unsigned OffW  = $clog2(BUS_BYTES);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned PendW = $clog2(DEPTH + 2);

  typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

  state_e state_q, state_d;

  // FIFO storage
  logic [31:0]          fifo_addr_q [DEPTH];
  logic [DataW-1:0]     fifo_data_q [DEPTH];
  logic [BUS_BYTES-1:0] fifo_be_q   [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;

  // Beat registers; hi_* holds the pending high beat while the low beat is on the bus
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [DataW-1:0]     mem_data_q, mem_data_d;
  logic [BUS_BYTES-1:0] mem_be_q, mem_be_d;
  logic [31:0]          hi_addr_q, hi_addr_d;
  logic [DataW-1:0]     hi_data_q, hi_data_d;
  logic [BUS_BYTES-1:0] hi_be_q, hi_be_d;

  logic push, pop, fifo_empty, beat_done, finish, go_high;

  // Head entry decoded into a double-width word
  logic [OffW-1:0]        head_off;
  logic [2*DataW-1:0]     head_wide_data;
  logic [2*BUS_BYTES-1:0] head_wide_be;
  logic [31:0]            head_lo_addr, head_hi_addr;
  logic                   head_lo_nz;

  always_comb begin
    head_off       = fifo_addr_q[rd_ptr_q][OffW-1:0];
    head_wide_data = {{DataW{1'b0}}, fifo_data_q[rd_ptr_q]} << {head_off, 3'b000};
    head_wide_be   = {{BUS_BYTES{1'b0}}, fifo_be_q[rd_ptr_q]} << head_off;
    head_lo_addr   = {fifo_addr_q[rd_ptr_q][31:OffW], {OffW{1'b0}}};
    head_hi_addr   = head_lo_addr + 32'(BUS_BYTES);  // wraps modulo 2^32
    head_lo_nz     = |head_wide_be[BUS_BYTES-1:0];
  end

  // Handshake and FIFO control
  always_comb begin
    fifo_empty = (count_q == '0);
    push       = write_req && write_ready && (|write_byte_enable);
    beat_done  = (state_q != StIdle) && mem_ready;
    // A request finishes after its last nonzero beat; idle counts as finished
    finish     = (state_q == StIdle) ||
                 (beat_done && ((state_q == StHigh) || (hi_be_q == '0)));
    go_high    = (state_q == StLow) && beat_done && (hi_be_q != '0);
    pop        = finish && !fifo_empty;
    count_d    = count_q + CntW'(push) - CntW'(pop);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StHigh: begin
        if (pop)         state_d = head_lo_nz ? StLow : StHigh;
        else if (finish) state_d = StIdle;
      end
      StLow: begin
        if (go_high)     state_d = StHigh;
        else if (pop)    state_d = head_lo_nz ? StLow : StHigh;
        else if (finish) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Beat register next values; hold when nothing changes so outputs stay stable
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_be_d   = mem_be_q;
    hi_addr_d  = hi_addr_q;
    hi_data_d  = hi_data_q;
    hi_be_d    = hi_be_q;
    if (go_high) begin
      mem_addr_d = hi_addr_q;
      mem_data_d = hi_data_q;
      mem_be_d   = hi_be_q;
    end else if (pop) begin
      hi_addr_d = head_hi_addr;
      hi_data_d = head_wide_data[2*DataW-1:DataW];
      hi_be_d   = head_wide_be[2*BUS_BYTES-1:BUS_BYTES];
      if (head_lo_nz) begin
        mem_addr_d = head_lo_addr;
        mem_data_d = head_wide_data[DataW-1:0];
        mem_be_d   = head_wide_be[BUS_BYTES-1:0];
      end else begin
        mem_addr_d = head_hi_addr;
        mem_data_d = head_wide_data[2*DataW-1:DataW];
        mem_be_d   = head_wide_be[2*BUS_BYTES-1:BUS_BYTES];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_be_q   <= '0;
      hi_addr_q  <= '0;
      hi_data_q  <= '0;
      hi_be_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_be_q   <= mem_be_d;
      hi_addr_q  <= hi_addr_d;
      hi_data_q  <= hi_data_d;
      hi_be_q    <= hi_be_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= write_addr;
      fifo_data_q[wr_ptr_q] <= write_data;
      fifo_be_q[wr_ptr_q]   <= write_byte_enable;
    end
  end

  // Outputs
  always_comb begin
    write_ready     = (count_q != CntW'(DEPTH));
    mem_write_req   = (state_q != StIdle);
    mem_addr        = mem_addr_q;
    mem_write_data  = mem_data_q;
    mem_byte_enable = mem_be_q;
    pending_count   = PendW'(count_q) + PendW'(state_q != StIdle);
    idle            = (pending_count == '0);
  end

endmodule

// File: tb/tb_store_buffer_unit.sv
module tb_store_buffer_unit;
  localparam int BB    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_ready;
  logic        write_req;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_byte_enable;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_write_req;
  logic [2:0]  pending_count;
  logic        idle;

  store_buffer_unit #(.BUS_BYTES(BB), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .write_ready       (write_ready),
    .write_req         (write_req),
    .write_addr        (write_addr),
    .write_data        (write_data),
    .write_byte_enable (write_byte_enable),
    .mem_ready         (mem_ready),
    .mem_addr          (mem_addr),
    .mem_write_data    (mem_write_data),
    .mem_byte_enable   (mem_byte_enable),
    .mem_write_req     (mem_write_req),
    .pending_count     (pending_count),
    .idle              (idle)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: expected beats in bus order, outstanding requests, and whether
  // a request currently occupies the bus.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } beat_t;

  beat_t beats[$];
  int    outstanding = 0;
  bit    loaded      = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Place every data byte at address addr+i; group bytes by aligned beat.
  function automatic void model_push(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    logic [31:0] lo_a, hi_a, ba;
    logic [31:0] lo_d, hi_d;
    logic [3:0]  lo_b, hi_b;
    int          lane;
    beat_t       bt;
    if (be == 4'h0) return;
    lo_d = '0; hi_d = '0; lo_b = '0; hi_b = '0;
    lo_a = a & ~32'(BB - 1);
    hi_a = lo_a + 32'(BB);
    for (int i = 0; i < BB; i++) begin
      ba   = a + 32'(i);
      lane = int'(ba % BB);
      if ((ba & ~32'(BB - 1)) == lo_a) begin
        lo_d[lane*8 +: 8] = d[i*8 +: 8];
        lo_b[lane]        = be[i];
      end else begin
        hi_d[lane*8 +: 8] = d[i*8 +: 8];
        hi_b[lane]        = be[i];
      end
    end
    if (lo_b != 4'h0) begin
      bt = '{addr: lo_a, data: lo_d, be: lo_b, last: (hi_b == 4'h0)};
      beats.push_back(bt);
    end
    if (hi_b != 4'h0) begin
      bt = '{addr: hi_a, data: hi_d, be: hi_b, last: 1'b1};
      beats.push_back(bt);
    end
    outstanding++;
  endfunction

  // Check the current cycle against the model, then advance model and DUT one edge.
  task automatic tick();
    int fifo_before;
    bit done, last, loaded_n;
    fifo_before = outstanding - int'(loaded);
    chk("write_ready", write_ready, fifo_before < DEPTH);
    chk("pending_count", pending_count, outstanding);
    chk("idle", idle, outstanding == 0);
    chk("mem_write_req", mem_write_req, loaded);
    if (loaded && beats.size() > 0) begin
      chk("mem_addr", mem_addr, beats[0].addr);
      chk("mem_write_data", mem_write_data, beats[0].data);
      chk("mem_byte_enable", mem_byte_enable, beats[0].be);
    end
    if (reset) begin
      beats.delete();
      outstanding = 0;
      loaded      = 1'b0;
    end else begin
      done = loaded && mem_ready && beats.size() > 0;
      last = 1'b0;
      if (done) begin
        last = beats[0].last;
        void'(beats.pop_front());
      end
      if (!loaded || (done && last)) loaded_n = (fifo_before > 0);
      else                           loaded_n = 1'b1;
      if (done && last) outstanding--;
      if (write_req && fifo_before < DEPTH) model_push(write_addr, write_data, write_byte_enable);
      loaded = loaded_n;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    write_req         = v;
    write_addr        = a;
    write_data        = d;
    write_byte_enable = be;
  endtask

  task automatic drain();
    int n;
    n = 0;
    set_req(1'b0, '0, '0, '0);
    mem_ready = 1'b1;
    while (outstanding > 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_bound", outstanding, 0);
    tick();
  endtask

  initial begin
    set_req(1'b0, '0, '0, '0);
    mem_ready = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_data", mem_write_data, 32'h0);
    chk("rst_mem_be", mem_byte_enable, 4'h0);
    tick();

    // Aligned single beat; latency checked by the per-cycle mem_write_req compare
    mem_ready = 1'b1;
    set_req(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    tick();
    set_req(1'b0, '0, '0, '0);
    tick();
    chk("lat_req_high", mem_write_req, 1'b1);
    chk("aligned_addr", mem_addr, 32'h100);
    chk("aligned_data", mem_write_data, 32'hDEADBEEF);
    drain();

    // Split store across two beats, with some back-pressure
    mem_ready = 1'b0;
    set_req(1'b1, 32'h103, 32'h11223344, 4'hF);
    tick();
    set_req(1'b0, '0, '0, '0);
    tick();
    chk("split_lo_data", mem_write_data, 32'h44000000);
    tick();
    mem_ready = 1'b1;
    tick();
    chk("split_hi_addr", mem_addr, 32'h104);
    chk("split_hi_data", mem_write_data, 32'h00112233);
    chk("split_hi_be", mem_byte_enable, 4'h7);
    drain();

    // Low beat skipped; then address wrap at the top of memory
    set_req(1'b1, 32'h102, 32'hAABBCCDD, 4'hC);
    tick();
    set_req(1'b1, 32'hFFFFFFFE, 32'h01020304, 4'hF);
    tick();
    set_req(1'b0, '0, '0, '0);
    chk("skip_lo_addr", mem_addr, 32'h104);
    chk("skip_lo_be", mem_byte_enable, 4'h3);
    drain();

    // Zero-enable store is discarded, then fill while memory stalls
    mem_ready = 1'b0;
    set_req(1'b1, 32'h200, 32'h12345678, 4'h0);
    tick();
    chk("be0_pending", pending_count, 3'd0);
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 32'h300 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
      tick();
    end
    set_req(1'b0, '0, '0, '0);
    chk("full_pending", pending_count, 3'd5);
    chk("full_ready", write_ready, 1'b0);
    drain();

    // Back-to-back aligned stores with memory always ready
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 32'h400 + 32'(4 * i), 32'hA0A0A0A0 ^ 32'(i), 4'hF);
      tick();
    end
    set_req(1'b0, '0, '0, '0);
    chk("b2b_req", mem_write_req, 1'b1);
    drain();
    chk("b2b_idle", idle, 1'b1);

    // Reset during the high beat with two entries queued
    mem_ready = 1'b0;
    set_req(1'b1, 32'h503, 32'h55667788, 4'hF);
    tick();
    set_req(1'b1, 32'h600, 32'h1, 4'hF);
    tick();
    set_req(1'b1, 32'h604, 32'h2, 4'hF);
    tick();
    set_req(1'b0, '0, '0, '0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("pre_rst_hi_addr", mem_addr, 32'h504);
    chk("pre_rst_pending", pending_count, 3'd3);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    mem_ready = 1'b1;
    chk("mid_rst_req", mem_write_req, 1'b0);
    chk("mid_rst_pending", pending_count, 3'd0);
    chk("mid_rst_ready", write_ready, 1'b1);
    repeat (4) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      write_req         = 1'($urandom_range(0, 1));
      write_addr        = $urandom;
      write_data        = $urandom;
      write_byte_enable = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      mem_ready         = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
